// File: rtl/instr_loader_if.sv
// Byte-stream handshake and instruction-memory write port for the program loader.
// The slave modport is the loader side; the master modport is the host/memory side.
interface instr_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              regWE;
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       DataIn;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, regWE, Addr, DataIn
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, regWE, Addr, DataIn
  );
endinterface

// File: rtl/instr_loader.sv
// Streams a length-prefixed, XOR-checksummed program into instruction memory as big-endian
// 32-bit words, holding the CPU until a load completes with a matching checksum.
module instr_loader #(
  parameter int unsigned WORDS  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  instr_loader_if.slave  bus,
  output logic           o_cpu_hold,
  output logic           o_done,
  output logic           o_error
);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StWrite, StCheck, StDone, StError
  } state_e;

  state_e      r_state;
  logic [7:0]  r_len_hi;
  logic [15:0] r_len;
  logic [15:0] r_wcnt;
  logic [1:0]  r_bcnt;
  logic [7:0]  r_chk;
  logic [31:0] r_data;
  logic        r_byte_ready;
  logic        r_regwe;
  logic        r_cpu_hold;
  logic        r_done;
  logic        r_error;

  logic        w_acc;
  logic [15:0] w_len;
  logic [15:0] w_wcnt_nxt;

  assign w_acc      = bus.byte_valid && r_byte_ready;
  assign w_len      = {r_len_hi, bus.byte_in};
  assign w_wcnt_nxt = r_wcnt + 16'd1;

  // Word counter is kept 16 bits wide so LEN = WORDS completes before any wrap of Addr.
  assign bus.byte_ready = r_byte_ready;
  assign bus.regWE      = r_regwe;
  assign bus.Addr       = r_wcnt[ADDR_W-1:0];
  assign bus.DataIn     = r_data;
  assign o_cpu_hold     = r_cpu_hold;
  assign o_done         = r_done;
  assign o_error        = r_error;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_len_hi     <= 8'h00;
      r_len        <= 16'h0000;
      r_wcnt       <= 16'h0000;
      r_bcnt       <= 2'd0;
      r_chk        <= 8'h00;
      r_data       <= 32'h0000_0000;
      r_byte_ready <= 1'b0;
      r_regwe      <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_regwe <= 1'b0;
      unique case (r_state)
        StIdle, StDone, StError: begin
          if (i_start) begin
            r_state      <= StLenHi;
            r_wcnt       <= 16'h0000;
            r_bcnt       <= 2'd0;
            r_chk        <= 8'h00;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_byte_ready <= 1'b1;
            r_cpu_hold   <= 1'b1;
          end
        end
        StLenHi: begin
          if (w_acc) begin
            r_len_hi <= bus.byte_in;
            r_state  <= StLenLo;
          end
        end
        StLenLo: begin
          if (w_acc) begin
            r_len <= w_len;
            if (w_len == 16'h0000) begin
              r_state <= StCheck;
            end else if (32'(w_len) > WORDS) begin
              r_state      <= StError;
              r_byte_ready <= 1'b0;
              r_error      <= 1'b1;
            end else begin
              r_state <= StData;
            end
          end
        end
        StData: begin
          if (w_acc) begin
            r_data <= {r_data[23:0], bus.byte_in};
            r_chk  <= r_chk ^ bus.byte_in;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_state      <= StWrite;
              r_regwe      <= 1'b1;
              r_byte_ready <= 1'b0;
            end
          end
        end
        StWrite: begin
          r_wcnt       <= w_wcnt_nxt;
          r_byte_ready <= 1'b1;
          r_state      <= (w_wcnt_nxt == r_len) ? StCheck : StData;
        end
        StCheck: begin
          if (w_acc) begin
            r_byte_ready <= 1'b0;
            if (bus.byte_in == r_chk) begin
              r_state    <= StDone;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= StError;
              r_error <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
